lrwait_bank_queue: RTL and testbench
====================================

Name: lrwait_bank_queue

Overview:
Bank-side half of the distributed MCS lock. It sits between the tile/group interconnect and one TCDM bank, consuming the LR, SC and WakeUp requests produced by per-core qnodes.
- Tracks, per reserved word address, the current head and tail of the waiting queue.
- Answers queued LRs with SuccUpdates addressed to the previous tail.
- Turns WakeUps into LR reads on behalf of the successor.
- Passes all other traffic straight through to the bank.

Parameters:
NumSlots, 4, number of concurrently tracked reserved addresses
AddrWidth, 32, request address width
DataWidth, 32, data width; must be >= MetaWidth
MetaWidth, 16, width of the routing metadata (ini_addr, meta_id, core_id, tile_id, lrwait bit)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
in_qaddr_i  in  AddrWidth  request address
in_qwrite_i  in  1  write enable
in_qamo_i  in  4  AMO opcode (amo_op_t)
in_qdata_i  in  DataWidth  write data; carries the successor metadata on a WakeUp
in_qstrb_i  in  4  byte strobe
in_qmeta_i  in  MetaWidth  requester routing metadata
in_qlrwait_i  in  1  request is a WakeUp
in_qvalid_i  in  1  request valid
in_qready_o  out  1  request ready
in_pdata_o  out  DataWidth  response data
in_pmeta_o  out  MetaWidth  response routing metadata
in_plrwait_o  out  1  response is a SuccUpdate
in_pvalid_o  out  1  response valid
in_pready_i  in  1  response ready
bank_qaddr_o  out  AddrWidth  bank request address
bank_qwrite_o  out  1  bank write enable
bank_qamo_o  out  4  bank AMO opcode
bank_qdata_o  out  DataWidth  bank write data
bank_qstrb_o  out  4  bank byte strobe
bank_qmeta_o  out  MetaWidth  bank request metadata
bank_qvalid_o  out  1  bank request valid
bank_qready_i  in  1  bank request ready
bank_pdata_i  in  DataWidth  bank response data
bank_pmeta_i  in  MetaWidth  bank response metadata
bank_pvalid_i  in  1  bank response valid
bank_pready_o  out  1  bank response ready

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- On reset: all slots invalid; SuccUpdate register empty; in_qready_o=0, in_pvalid_o=0, bank_qvalid_o=0, bank_pready_o=0. All data outputs are 0.
- Slot contents: valid, addr (word-aligned, addr[AddrWidth-1:2]), head_valid, head meta, tail meta.
- Address match is a combinational lookup over all slots. At most one slot may match (assertion).
- Classification of the accepted request (one per cycle):
  - Plain access (amo not LR/SC, lrwait=0): forwarded unchanged. in_qready_o=bank_qready_i.
  - LR, miss, free slot exists: allocate the lowest free index with head=tail=requester and head_valid=1. Forward to the bank. Accepted only on bank handshake.
  - LR, miss, table full: forwarded as a plain LR with no queueing. The later SC is forwarded unchanged and the bank decides.
  - LR, hit: not forwarded; no bank access.
    - Load the SuccUpdate register: pdata = requester meta zero-extended, pmeta = old tail meta, plrwait = 1.
    - Set tail = requester meta.
    - in_qready_o=1 only if the SuccUpdate register is empty; otherwise stall.
    - The requester receives no response until its WakeUp.
  - SC, hit, requester meta == head meta and head_valid:
    - Forward to the bank.
    - If tail == head, free the slot.
    - Otherwise clear head_valid and keep the slot.
  - SC, hit, requester not head: not forwarded. Reply locally with pdata=1 (fail), pmeta=requester meta, plrwait=0, through the SuccUpdate register path.
  - SC, miss: forwarded unchanged.
  - WakeUp (lrwait=1, amo=LR), hit:
    - Set head = in_qdata_i[MetaWidth-1:0] and head_valid=1.
    - Issue an LR to the bank with bank_qmeta_o = successor meta, bank_qdata_o = 0.
    - The bank response therefore routes to the successor.
  - WakeUp, miss: assertion failure; forwarded as a plain LR with the successor meta.
- Response path:
  - Bank responses have priority and pass through combinationally.
  - The SuccUpdate/local-fail register drives in_p* only when bank_pvalid_i=0.
  - bank_pready_o=in_pready_i.
  - The register holds until an in_p handshake. Its occupancy is 1 entry.
- Latency:
  - Forwarded requests: 0 cycles (combinational pass-through).
  - SuccUpdate: earliest appearance is the cycle after acceptance.
- Table updates commit on the request handshake edge only.
- Reset mid-operation clears all slots. Queued cores are lost; software must reissue.

Decomposition:
- lrwait_pkg holds the following, shared with the core-side qnode:
  - amo_op_t (AMONone..AMOSC, with AMOLR=4'hA and AMOSC=4'hB).
  - MetaWidth computation.
  - The slot struct typedef.
- One sub-module, lrwait_slot_table. It does the CAM lookup, lowest-free allocation, and head/tail/free update ports. The top level keeps classification, the request mux and the response register.

Test Plan:
- Core A (meta 0x011) LR to 0x100 on an empty table -> bank LR forwarded; slot0 holds head=tail=0x011; response to 0x011 with plrwait=0.
- Core B (0x022) LR to 0x100 -> no bank request; next cycle a SuccUpdate with pmeta=0x011, pdata=0x022, plrwait=1; tail=0x022.
- A SCs 0x100 -> forwarded, head_valid=0, slot kept. WakeUp with qdata=0x022 -> bank LR with meta 0x022; head=0x022. B SCs -> slot freed.
- Non-head C (0x033) SCs 0x100 while A is head -> no bank access; local response pdata=1, pmeta=0x033.
- Fill 4 slots (0x100..0x10C), then an LR to 0x200 -> forwarded as a plain LR; table unchanged; a following SC to 0x200 is forwarded.
- SuccUpdate pending with in_pready_i=0 while a second queued LR and a bank response arrive together -> the LR stalls (in_qready_o=0); the bank response wins the output; the SuccUpdate is emitted after.

Source files
------------

// File: rtl/lrwait_pkg.sv
// Shared LRWait types: AMO opcodes, qnode routing metadata width and the
// bank-side reservation slot layout.
package lrwait_pkg;

    typedef enum logic [3:0] {
        AMONone = 4'h0,
        AMOSwap = 4'h1,
        AMOAdd  = 4'h2,
        AMOAnd  = 4'h3,
        AMOOr   = 4'h4,
        AMOXor  = 4'h5,
        AMOMax  = 4'h6,
        AMOMaxu = 4'h7,
        AMOMin  = 4'h8,
        AMOMinu = 4'h9,
        AMOLR   = 4'hA,
        AMOSC   = 4'hB
    } amo_op_t;

    localparam int IniAddrWidth = 5;
    localparam int MetaIdWidth  = 4;
    localparam int CoreIdWidth  = 3;
    localparam int TileIdWidth  = 3;

    // ini_addr + meta_id + core_id + tile_id + lrwait bit
    localparam int QnodeMetaWidth =
        IniAddrWidth + MetaIdWidth + CoreIdWidth + TileIdWidth + 1;

    localparam int SlotAddrWidth = 30;

    typedef logic [QnodeMetaWidth-1:0] meta_t;

    typedef struct packed {
        logic                     valid;
        logic [SlotAddrWidth-1:0] addr;
        logic                     head_valid;
        meta_t                    head;
        meta_t                    tail;
    } slot_t;

endpackage

// File: rtl/lrwait_slot_table.sv
// Reservation table: CAM lookup on the word address, lowest-free
// allocation and head/tail/release updates on the matching slot.
module lrwait_slot_table
    import lrwait_pkg::*;
#(
    parameter int NumSlots = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SlotAddrWidth-1:0] addr,
    output logic                     hit,
    output logic                     hit_head_valid,
    output meta_t                    hit_head,
    output meta_t                    hit_tail,
    output logic                     full,
    input  logic                     alloc_en,
    input  meta_t                    alloc_meta,
    input  logic                     tail_en,
    input  meta_t                    tail_meta,
    input  logic                     head_en,
    input  meta_t                    head_meta,
    input  logic                     release_en
);

    localparam int IdxWidth = (NumSlots > 1) ? $clog2(NumSlots) : 1;

    slot_t               slots_q [NumSlots];
    logic [NumSlots-1:0] match;
    logic [NumSlots-1:0] free;
    logic [IdxWidth-1:0] hit_idx;
    logic [IdxWidth-1:0] free_idx;

    // Walk downwards so the lowest index wins
    always_comb begin
        match    = '0;
        free     = '0;
        hit_idx  = '0;
        free_idx = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            match[i] = slots_q[i].valid && (slots_q[i].addr == addr);
            free[i]  = !slots_q[i].valid;
            if (match[i]) hit_idx = IdxWidth'(i);
            if (free[i]) free_idx = IdxWidth'(i);
        end
    end

    assign hit            = |match;
    assign full           = ~|free;
    assign hit_head_valid = slots_q[hit_idx].head_valid;
    assign hit_head       = slots_q[hit_idx].head;
    assign hit_tail       = slots_q[hit_idx].tail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumSlots; i++) slots_q[i] <= '0;
        end else begin
            if (alloc_en && !hit && !full) begin
                slots_q[free_idx] <= '{
                    valid:      1'b1,
                    addr:       addr,
                    head_valid: 1'b1,
                    head:       alloc_meta,
                    tail:       alloc_meta
                };
            end
            if (hit && tail_en) slots_q[hit_idx].tail <= tail_meta;
            if (hit && head_en) begin
                slots_q[hit_idx].head       <= head_meta;
                slots_q[hit_idx].head_valid <= 1'b1;
            end
            if (hit && release_en) begin
                if (hit_tail == hit_head) slots_q[hit_idx].valid <= 1'b0;
                else slots_q[hit_idx].head_valid <= 1'b0;
            end
        end
    end

    a_single_match: assert property (
        @(posedge clk) disable iff (!rst_n) $onehot0(match)
    );

endmodule

// File: rtl/lrwait_bank_queue.sv
// Bank-side LRWait queue: classifies LR/SC/WakeUp traffic, keeps the MCS
// waiting queue per reserved word and emits SuccUpdates / local SC fails.
module lrwait_bank_queue
    import lrwait_pkg::*;
#(
    parameter int NumSlots  = 4,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int MetaWidth = QnodeMetaWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [AddrWidth-1:0] in_qaddr_i,
    input  logic                 in_qwrite_i,
    input  logic [3:0]           in_qamo_i,
    input  logic [DataWidth-1:0] in_qdata_i,
    input  logic [3:0]           in_qstrb_i,
    input  logic [MetaWidth-1:0] in_qmeta_i,
    input  logic                 in_qlrwait_i,
    input  logic                 in_qvalid_i,
    output logic                 in_qready_o,
    output logic [DataWidth-1:0] in_pdata_o,
    output logic [MetaWidth-1:0] in_pmeta_o,
    output logic                 in_plrwait_o,
    output logic                 in_pvalid_o,
    input  logic                 in_pready_i,
    output logic [AddrWidth-1:0] bank_qaddr_o,
    output logic                 bank_qwrite_o,
    output logic [3:0]           bank_qamo_o,
    output logic [DataWidth-1:0] bank_qdata_o,
    output logic [3:0]           bank_qstrb_o,
    output logic [MetaWidth-1:0] bank_qmeta_o,
    output logic                 bank_qvalid_o,
    input  logic                 bank_qready_i,
    input  logic [DataWidth-1:0] bank_pdata_i,
    input  logic [MetaWidth-1:0] bank_pmeta_i,
    input  logic                 bank_pvalid_i,
    output logic                 bank_pready_o
);

    logic  is_lr, is_sc, wake, lr_req;
    logic  hit, full, hit_head_valid;
    meta_t hit_head, hit_tail;
    logic  sc_is_head, lr_hit, sc_fail, local_req, hs;

    logic                 su_valid_q;
    logic [DataWidth-1:0] su_data_q;
    logic [MetaWidth-1:0] su_meta_q;
    logic                 su_lrwait_q;

    assign is_lr  = in_qamo_i == 4'(AMOLR);
    assign is_sc  = in_qamo_i == 4'(AMOSC);
    assign wake   = is_lr && in_qlrwait_i;
    assign lr_req = is_lr && !in_qlrwait_i;

    assign sc_is_head = hit_head_valid && (hit_head == in_qmeta_i);
    assign lr_hit     = lr_req && hit;
    assign sc_fail    = is_sc && hit && !sc_is_head;
    assign local_req  = lr_hit || sc_fail;

    // Local requests only need room in the response register
    assign in_qready_o   = rst_ni && (local_req ? !su_valid_q : bank_qready_i);
    assign bank_qvalid_o = rst_ni && in_qvalid_i && !local_req;
    assign hs            = in_qvalid_i && in_qready_o;

    lrwait_slot_table #(
        .NumSlots (NumSlots)
    ) i_table (
        .clk            (clk_i),
        .rst_n          (rst_ni),
        .addr           (in_qaddr_i[AddrWidth-1:2]),
        .hit            (hit),
        .hit_head_valid (hit_head_valid),
        .hit_head       (hit_head),
        .hit_tail       (hit_tail),
        .full           (full),
        .alloc_en       (hs && lr_req && !hit),
        .alloc_meta     (in_qmeta_i),
        .tail_en        (hs && lr_hit),
        .tail_meta      (in_qmeta_i),
        .head_en        (hs && wake),
        .head_meta      (in_qdata_i[MetaWidth-1:0]),
        .release_en     (hs && is_sc && hit && sc_is_head)
    );

    // A WakeUp reads on behalf of the successor carried in the data field
    always_comb begin
        bank_qaddr_o  = '0;
        bank_qwrite_o = 1'b0;
        bank_qamo_o   = '0;
        bank_qdata_o  = '0;
        bank_qstrb_o  = '0;
        bank_qmeta_o  = '0;
        if (rst_ni) begin
            bank_qaddr_o  = in_qaddr_i;
            bank_qwrite_o = in_qwrite_i;
            bank_qamo_o   = in_qamo_i;
            bank_qstrb_o  = in_qstrb_i;
            bank_qdata_o  = wake ? '0 : in_qdata_i;
            bank_qmeta_o  = wake ? in_qdata_i[MetaWidth-1:0] : in_qmeta_i;
        end
    end

    always_comb begin
        in_pdata_o   = '0;
        in_pmeta_o   = '0;
        in_plrwait_o = 1'b0;
        in_pvalid_o  = 1'b0;
        if (rst_ni && bank_pvalid_i) begin
            in_pdata_o  = bank_pdata_i;
            in_pmeta_o  = bank_pmeta_i;
            in_pvalid_o = 1'b1;
        end else if (su_valid_q) begin
            in_pdata_o   = su_data_q;
            in_pmeta_o   = su_meta_q;
            in_plrwait_o = su_lrwait_q;
            in_pvalid_o  = 1'b1;
        end
    end

    assign bank_pready_o = rst_ni && in_pready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            su_valid_q  <= 1'b0;
            su_data_q   <= '0;
            su_meta_q   <= '0;
            su_lrwait_q <= 1'b0;
        end else begin
            if (su_valid_q && !bank_pvalid_i && in_pready_i) su_valid_q <= 1'b0;
            if (hs && local_req) begin
                su_valid_q  <= 1'b1;
                su_data_q   <= lr_hit ? DataWidth'(in_qmeta_i) : DataWidth'(1);
                su_meta_q   <= lr_hit ? hit_tail : in_qmeta_i;
                su_lrwait_q <= lr_hit;
            end
        end
    end

    a_wake_hit: assert property (
        @(posedge clk_i) disable iff (!rst_ni) (in_qvalid_i && wake) |-> hit
    );

endmodule

// File: tb/tb_lrwait_bank_queue.sv
// Bench for lrwait_bank_queue: directed vector table, handshake corner
// sequences and a randomized run against a queue-level reference model.
module tb_lrwait_bank_queue;

    localparam logic [3:0] LR = 4'hA;
    localparam logic [3:0] SC = 4'hB;
    localparam logic [3:0] NO = 4'h0;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [31:0] in_qaddr_i;
    logic        in_qwrite_i;
    logic [3:0]  in_qamo_i;
    logic [31:0] in_qdata_i;
    logic [3:0]  in_qstrb_i;
    logic [15:0] in_qmeta_i;
    logic        in_qlrwait_i;
    logic        in_qvalid_i;
    logic        in_qready_o;
    logic [31:0] in_pdata_o;
    logic [15:0] in_pmeta_o;
    logic        in_plrwait_o;
    logic        in_pvalid_o;
    logic        in_pready_i;
    logic [31:0] bank_qaddr_o;
    logic        bank_qwrite_o;
    logic [3:0]  bank_qamo_o;
    logic [31:0] bank_qdata_o;
    logic [3:0]  bank_qstrb_o;
    logic [15:0] bank_qmeta_o;
    logic        bank_qvalid_o;
    logic        bank_qready_i;
    logic [31:0] bank_pdata_i;
    logic [15:0] bank_pmeta_i;
    logic        bank_pvalid_i;
    logic        bank_pready_o;

    always #5 clk = ~clk;

    lrwait_bank_queue dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .in_qaddr_i    (in_qaddr_i),
        .in_qwrite_i   (in_qwrite_i),
        .in_qamo_i     (in_qamo_i),
        .in_qdata_i    (in_qdata_i),
        .in_qstrb_i    (in_qstrb_i),
        .in_qmeta_i    (in_qmeta_i),
        .in_qlrwait_i  (in_qlrwait_i),
        .in_qvalid_i   (in_qvalid_i),
        .in_qready_o   (in_qready_o),
        .in_pdata_o    (in_pdata_o),
        .in_pmeta_o    (in_pmeta_o),
        .in_plrwait_o  (in_plrwait_o),
        .in_pvalid_o   (in_pvalid_o),
        .in_pready_i   (in_pready_i),
        .bank_qaddr_o  (bank_qaddr_o),
        .bank_qwrite_o (bank_qwrite_o),
        .bank_qamo_o   (bank_qamo_o),
        .bank_qdata_o  (bank_qdata_o),
        .bank_qstrb_o  (bank_qstrb_o),
        .bank_qmeta_o  (bank_qmeta_o),
        .bank_qvalid_o (bank_qvalid_o),
        .bank_qready_i (bank_qready_i),
        .bank_pdata_i  (bank_pdata_i),
        .bank_pmeta_i  (bank_pmeta_i),
        .bank_pvalid_i (bank_pvalid_i),
        .bank_pready_o (bank_pready_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  amo;
        logic        write;
        logic [31:0] addr;
        logic [15:0] meta;
        logic [31:0] data;
        logic        lrwait;
        logic        qready;
        logic        e_bvalid;
        logic        e_ready;
        logic [15:0] e_bmeta;
        logic [31:0] e_bdata;
        logic        e_pvalid;
        logic [31:0] e_pdata;
        logic [15:0] e_pmeta;
        logic        e_plrwait;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        logic [3:0] amo, logic write, logic [31:0] addr, logic [15:0] meta,
        logic [31:0] data, logic lrwait, logic qready,
        logic e_bvalid, logic e_ready, logic [15:0] e_bmeta,
        logic [31:0] e_bdata, logic e_pvalid, logic [31:0] e_pdata,
        logic [15:0] e_pmeta, logic e_plrwait);
        vec_t v;
        v.amo = amo; v.write = write; v.addr = addr; v.meta = meta;
        v.data = data; v.lrwait = lrwait; v.qready = qready;
        v.e_bvalid = e_bvalid; v.e_ready = e_ready; v.e_bmeta = e_bmeta;
        v.e_bdata = e_bdata; v.e_pvalid = e_pvalid; v.e_pdata = e_pdata;
        v.e_pmeta = e_pmeta; v.e_plrwait = e_plrwait;
        return v;
    endfunction

    task automatic idle_inputs();
        in_qaddr_i = '0; in_qwrite_i = 1'b0; in_qamo_i = '0;
        in_qdata_i = '0; in_qstrb_i = 4'hF; in_qmeta_i = '0;
        in_qlrwait_i = 1'b0; in_qvalid_i = 1'b0;
        bank_qready_i = 1'b1; in_pready_i = 1'b1;
        bank_pdata_i = '0; bank_pmeta_i = '0; bank_pvalid_i = 1'b0;
    endtask

    task automatic drive_req(input logic [3:0] amo, input logic write,
                             input logic [31:0] addr, input logic [15:0] meta,
                             input logic [31:0] data, input logic lrwait);
        in_qamo_i = amo; in_qwrite_i = write; in_qaddr_i = addr;
        in_qmeta_i = meta; in_qdata_i = data; in_qlrwait_i = lrwait;
        in_qvalid_i = 1'b1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic apply(input vec_t v, input int n);
        @(posedge clk); #1;
        drive_req(v.amo, v.write, v.addr, v.meta, v.data, v.lrwait);
        bank_qready_i = v.qready;
        @(negedge clk);
        check($sformatf("v%0d bank_qvalid", n), 64'(bank_qvalid_o), 64'(v.e_bvalid));
        check($sformatf("v%0d in_qready", n), 64'(in_qready_o), 64'(v.e_ready));
        if (v.e_bvalid) begin
            check($sformatf("v%0d bank_qmeta", n), 64'(bank_qmeta_o), 64'(v.e_bmeta));
            check($sformatf("v%0d bank_qdata", n), 64'(bank_qdata_o), 64'(v.e_bdata));
            check($sformatf("v%0d bank_qaddr", n), 64'(bank_qaddr_o), 64'(v.addr));
        end
        @(posedge clk); #1;
        in_qvalid_i = 1'b0;
        bank_qready_i = 1'b1;
        @(negedge clk);
        check($sformatf("v%0d in_pvalid", n), 64'(in_pvalid_o), 64'(v.e_pvalid));
        if (v.e_pvalid) begin
            check($sformatf("v%0d in_pdata", n), 64'(in_pdata_o), 64'(v.e_pdata));
            check($sformatf("v%0d in_pmeta", n), 64'(in_pmeta_o), 64'(v.e_pmeta));
            check($sformatf("v%0d in_plrwait", n), 64'(in_plrwait_o), 64'(v.e_plrwait));
        end
    endtask

    // Reference model: a list of reservations, each an MCS queue window
    logic        m_valid [4];
    logic [29:0] m_word  [4];
    logic        m_hv    [4];
    logic [15:0] m_head  [4];
    logic [15:0] m_tail  [4];
    logic        su_v;
    logic [31:0] su_d;
    logic [15:0] su_m;
    logic        su_l;

    function automatic int m_find(input logic [31:0] addr);
        for (int i = 0; i < 4; i++)
            if (m_valid[i] && m_word[i] == addr[31:2]) return i;
        return -1;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < 4; i++)
            if (!m_valid[i]) return i;
        return -1;
    endfunction

    task automatic random_run(input int cycles);
        logic [31:0] addrs [6];
        logic [15:0] metas [4];
        addrs = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h200};
        metas = '{16'h011, 16'h022, 16'h033, 16'h044};
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0; m_hv[i] = 1'b0;
            m_word[i] = '0; m_head[i] = '0; m_tail[i] = '0;
        end
        su_v = 1'b0; su_d = '0; su_m = '0; su_l = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            int r, idx, pick;
            logic [3:0] amo;
            logic [31:0] addr, data;
            logic [15:0] meta;
            logic lrw, vld, qr, loc, lrq, wk, exp_ready, exp_bvalid;
            @(posedge clk); #1;
            r = int'($urandom_range(0, 9));
            addr = addrs[$urandom_range(0, 5)] + 32'($urandom_range(0, 3));
            meta = metas[$urandom_range(0, 3)];
            data = $urandom;
            lrw = 1'b0;
            amo = NO;
            if (r <= 3) amo = LR;
            else if (r <= 6) amo = SC;
            else if (r == 7) begin
                pick = int'($urandom_range(0, 3));
                if (m_valid[pick]) begin
                    amo = LR; lrw = 1'b1;
                    addr = {m_word[pick], 2'b00};
                    data = {16'h0, metas[$urandom_range(0, 3)]};
                end
            end else amo = 4'($urandom_range(0, 2));
            vld = $urandom_range(0, 3) != 0;
            qr  = $urandom_range(0, 3) != 0;
            drive_req(amo, (amo == NO) && r[0], addr, meta, data, lrw);
            in_qvalid_i = vld;
            bank_qready_i = qr;
            idx = m_find(addr);
            lrq = (amo == LR) && !lrw;
            wk  = (amo == LR) && lrw;
            loc = (idx >= 0) && (lrq ||
                  ((amo == SC) && !(m_hv[idx] && m_head[idx] == meta)));
            exp_ready  = loc ? !su_v : qr;
            exp_bvalid = vld && !loc;
            @(negedge clk);
            check($sformatf("rnd%0d bank_qvalid", c), 64'(bank_qvalid_o), 64'(exp_bvalid));
            if (vld)
                check($sformatf("rnd%0d in_qready", c), 64'(in_qready_o), 64'(exp_ready));
            if (exp_bvalid) begin
                check($sformatf("rnd%0d bank_qmeta", c), 64'(bank_qmeta_o),
                      64'(wk ? data[15:0] : meta));
                check($sformatf("rnd%0d bank_qdata", c), 64'(bank_qdata_o),
                      64'(wk ? 32'h0 : data));
                check($sformatf("rnd%0d bank_qaddr", c), 64'(bank_qaddr_o), 64'(addr));
            end
            check($sformatf("rnd%0d in_pvalid", c), 64'(in_pvalid_o), 64'(su_v));
            if (su_v) begin
                check($sformatf("rnd%0d in_pdata", c), 64'(in_pdata_o), 64'(su_d));
                check($sformatf("rnd%0d in_pmeta", c), 64'(in_pmeta_o), 64'(su_m));
                check($sformatf("rnd%0d in_plrwait", c), 64'(in_plrwait_o), 64'(su_l));
            end
            su_v = 1'b0;
            if (vld && exp_ready) begin
                if (lrq && idx < 0) begin
                    pick = m_free();
                    if (pick >= 0) begin
                        m_valid[pick] = 1'b1; m_word[pick] = addr[31:2];
                        m_hv[pick] = 1'b1; m_head[pick] = meta; m_tail[pick] = meta;
                    end
                end else if (lrq) begin
                    su_v = 1'b1; su_d = {16'h0, meta}; su_m = m_tail[idx]; su_l = 1'b1;
                    m_tail[idx] = meta;
                end else if (amo == SC && idx >= 0) begin
                    if (loc) begin
                        su_v = 1'b1; su_d = 32'd1; su_m = meta; su_l = 1'b0;
                    end else if (m_tail[idx] == m_head[idx]) m_valid[idx] = 1'b0;
                    else m_hv[idx] = 1'b0;
                end else if (wk && idx >= 0) begin
                    m_head[idx] = data[15:0]; m_hv[idx] = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        do_reset();
        rst_ni = 1'b0;
        #1;
        check("reset in_qready", 64'(in_qready_o), 64'd0);
        check("reset bank_qvalid", 64'(bank_qvalid_o), 64'd0);
        check("reset in_pvalid", 64'(in_pvalid_o), 64'd0);
        check("reset bank_pready", 64'(bank_pready_o), 64'd0);
        check("reset bank_qaddr", 64'(bank_qaddr_o), 64'd0);
        check("reset in_pdata", 64'(in_pdata_o), 64'd0);
        do_reset();

        vecs.push_back(mk(LR, 0, 32'h100, 16'h011, 0, 0, 1, 1, 1, 16'h011, 0, 0, 0, 0, 0));
        vecs.push_back(mk(LR, 0, 32'h100, 16'h022, 0, 0, 1, 0, 1, 0, 0, 1, 32'h022, 16'h011, 1));
        vecs.push_back(mk(SC, 1, 32'h100, 16'h033, 0, 0, 1, 0, 1, 0, 0, 1, 32'h1, 16'h033, 0));
        vecs.push_back(mk(SC, 1, 32'h100, 16'h011, 32'hABCD, 0, 1, 1, 1, 16'h011, 32'hABCD, 0, 0, 0, 0));
        vecs.push_back(mk(LR, 0, 32'h100, 16'h011, 32'h022, 1, 1, 1, 1, 16'h022, 0, 0, 0, 0, 0));
        vecs.push_back(mk(SC, 1, 32'h100, 16'h022, 5, 0, 1, 1, 1, 16'h022, 5, 0, 0, 0, 0));
        vecs.push_back(mk(SC, 1, 32'h100, 16'h022, 6, 0, 1, 1, 1, 16'h022, 6, 0, 0, 0, 0));
        vecs.push_back(mk(LR, 0, 32'h100, 16'h044, 0, 0, 1, 1, 1, 16'h044, 0, 0, 0, 0, 0));
        vecs.push_back(mk(LR, 0, 32'h104, 16'h055, 0, 0, 1, 1, 1, 16'h055, 0, 0, 0, 0, 0));
        vecs.push_back(mk(LR, 0, 32'h108, 16'h066, 0, 0, 1, 1, 1, 16'h066, 0, 0, 0, 0, 0));
        vecs.push_back(mk(LR, 0, 32'h10C, 16'h077, 0, 0, 1, 1, 1, 16'h077, 0, 0, 0, 0, 0));
        vecs.push_back(mk(LR, 0, 32'h200, 16'h088, 0, 0, 1, 1, 1, 16'h088, 0, 0, 0, 0, 0));
        vecs.push_back(mk(SC, 1, 32'h200, 16'h088, 7, 0, 1, 1, 1, 16'h088, 7, 0, 0, 0, 0));
        vecs.push_back(mk(LR, 0, 32'h200, 16'h099, 0, 0, 1, 1, 1, 16'h099, 0, 0, 0, 0, 0));
        vecs.push_back(mk(LR, 0, 32'h10C, 16'h0AA, 0, 0, 1, 0, 1, 0, 0, 1, 32'h0AA, 16'h077, 1));
        vecs.push_back(mk(NO, 1, 32'h104, 16'h0BB, 32'h12345678, 0, 1, 1, 1, 16'h0BB, 32'h12345678, 0, 0, 0, 0));
        vecs.push_back(mk(LR, 0, 32'h300, 16'h0CC, 0, 0, 0, 1, 0, 16'h0CC, 0, 0, 0, 0, 0));
        vecs.push_back(mk(LR, 0, 32'h108, 16'h0DD, 0, 0, 1, 0, 1, 0, 0, 1, 32'h0DD, 16'h066, 1));
        vecs.push_back(mk(SC, 1, 32'h104, 16'h055, 0, 0, 1, 1, 1, 16'h055, 0, 0, 0, 0, 0));
        vecs.push_back(mk(LR, 0, 32'h104, 16'h0EE, 0, 0, 1, 1, 1, 16'h0EE, 0, 0, 0, 0, 0));
        vecs.push_back(mk(LR, 0, 32'h104, 16'h0FF, 0, 0, 1, 0, 1, 0, 0, 1, 32'h0FF, 16'h0EE, 1));
        vecs.push_back(mk(LR, 0, 32'h102, 16'h0AB, 0, 0, 1, 0, 1, 0, 0, 1, 32'h0AB, 16'h044, 1));
        foreach (vecs[i]) apply(vecs[i], i);

        // Pending SuccUpdate, then reset mid-operation clears it and the table
        @(posedge clk); #1;
        in_pready_i = 1'b0;
        drive_req(LR, 0, 32'h10C, 16'h0BC, 0, 0);
        @(posedge clk); #1;
        in_qvalid_i = 1'b0;
        @(negedge clk);
        check("pre-rst in_pvalid", 64'(in_pvalid_o), 64'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("async rst in_pvalid", 64'(in_pvalid_o), 64'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        in_pready_i = 1'b1;
        apply(mk(LR, 0, 32'h10C, 16'h111, 0, 0, 1, 1, 1, 16'h111, 0, 0, 0, 0, 0), 100);

        // Bank response wins over a pending SuccUpdate; queued LR stalls
        do_reset();
        @(posedge clk); #1;
        drive_req(LR, 0, 32'h100, 16'h011, 0, 0);
        @(posedge clk); #1;
        drive_req(LR, 0, 32'h100, 16'h022, 0, 0);
        @(posedge clk); #1;
        in_pready_i = 1'b0;
        drive_req(LR, 0, 32'h100, 16'h033, 0, 0);
        bank_pvalid_i = 1'b1; bank_pdata_i = 32'h5A5A; bank_pmeta_i = 16'h011;
        @(negedge clk);
        check("race in_qready", 64'(in_qready_o), 64'd0);
        check("race bank_qvalid", 64'(bank_qvalid_o), 64'd0);
        check("race in_pdata", 64'(in_pdata_o), 64'h5A5A);
        check("race in_pmeta", 64'(in_pmeta_o), 64'h011);
        check("race in_plrwait", 64'(in_plrwait_o), 64'd0);
        check("race bank_pready", 64'(bank_pready_o), 64'd0);
        @(posedge clk); #1;
        bank_pvalid_i = 1'b0;
        in_pready_i = 1'b1;
        @(negedge clk);
        check("su after in_pvalid", 64'(in_pvalid_o), 64'd1);
        check("su after in_pdata", 64'(in_pdata_o), 64'h022);
        check("su after in_pmeta", 64'(in_pmeta_o), 64'h011);
        check("su after in_plrwait", 64'(in_plrwait_o), 64'd1);
        check("su after in_qready", 64'(in_qready_o), 64'd0);
        @(negedge clk);
        check("drained in_qready", 64'(in_qready_o), 64'd1);
        check("drained in_pvalid", 64'(in_pvalid_o), 64'd0);
        @(posedge clk); #1;
        in_qvalid_i = 1'b0;
        @(negedge clk);
        check("c su in_pdata", 64'(in_pdata_o), 64'h033);
        check("c su in_pmeta", 64'(in_pmeta_o), 64'h022);
        check("c su in_plrwait", 64'(in_plrwait_o), 64'd1);

        do_reset();
        random_run(600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
